// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Default sizes and the hard-wired zero register address.
package rf_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_wb_if.sv
// Write-back bus: requester handshakes, RF write port and bypass query.
// master = requester/consumer side, slave = the arbiter.
interface rf_wb_if #(
  parameter int NREQ = rf_pkg::NREQ_DEF,
  parameter int AW   = rf_pkg::AW_DEF,
  parameter int DW   = rf_pkg::DW_DEF
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               RegWrite;
  logic [AW-1:0]      WriteAddr;
  logic [DW-1:0]      WriteData;
  logic [AW-1:0]      q_addr1;
  logic [AW-1:0]      q_addr2;
  logic               q_hit1;
  logic               q_hit2;
  logic [DW-1:0]      q_data1;
  logic [DW-1:0]      q_data2;

  modport master (
    output req_valid, req_addr, req_data, hold, q_addr1, q_addr2,
    input  req_ready, RegWrite, WriteAddr, WriteData,
    input  q_hit1, q_hit2, q_data1, q_data2
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold, q_addr1, q_addr2,
    output req_ready, RegWrite, WriteAddr, WriteData,
    output q_hit1, q_hit2, q_data1, q_data2
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last winner.
// The pointer moves to the winner only when advance_i reports an accept.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   last_o
);

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    win_idx = last_q;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(last_q) + k) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        win_idx      = idx;
        found        = 1'b1;
      end
    end
  end

  assign last_d = advance_i ? win_idx : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between NREQ write-back requesters; the winner is
// registered and written one cycle later, with a bypass view of that write.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int AW   = AW_DEF,
  parameter  int DW   = DW_DEF,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic    clk,
  input  logic    rst,
  rf_wb_if.slave  bus
);

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   unused_rr_last;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req_valid),
    .advance_i (accept),
    .grant_o   (grant),
    .last_o    (unused_rr_last)
  );

  // Ready is the grant itself, so it may depend on valid in the same cycle.
  assign bus.req_ready = grant & {NREQ{~bus.hold & ~rst}};
  assign accept        = |bus.req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (accept) begin
      waddr_d    = sel_addr;
      wdata_d    = sel_data;
      regwrite_d = (sel_addr != AW'(REG_ZERO));
    end
  end

  // Write-back register stage: accept at edge N, RF write during cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.RegWrite  = regwrite_q;
  assign bus.WriteAddr = waddr_q;
  assign bus.WriteData = wdata_q;

  assign bus.q_hit1  = regwrite_q && (waddr_q == bus.q_addr1) && (bus.q_addr1 != AW'(REG_ZERO));
  assign bus.q_hit2  = regwrite_q && (waddr_q == bus.q_addr2) && (bus.q_addr2 != AW'(REG_ZERO));
  assign bus.q_data1 = bus.q_hit1 ? wdata_q : '0;
  assign bus.q_data2 = bus.q_hit2 ? wdata_q : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with NREQ=3, AW=5, DW=32.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_wb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk_eq({tag, ".we"},   64'(bus.RegWrite),  64'(we));
    chk_eq({tag, ".addr"}, 64'(bus.WriteAddr), 64'(a));
    chk_eq({tag, ".data"}, 64'(bus.WriteData), 64'(d));
  endtask

  logic [NREQ-1:0] exp_g;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    bus.q_addr1   = '0;
    bus.q_addr2   = '0;

    // Reset: outputs cleared, ready forced low even with all requesters valid
    tick();
    bus.req_valid = 3'b111;
    tick();
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk_eq("rst.ready", 64'(bus.req_ready), 64'b000);
    rst = 1'b0;
    #1;
    chk_eq("post_rst.grant0", 64'(bus.req_ready), 64'b001);

    // Single write from requester 0
    bus.req_valid = '0;
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk_eq("single.ready", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_valid = '0;
    #1;
    chk_wr("single.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    chk_eq("single.idle_ready", 64'(bus.req_ready), 64'b000);
    tick();
    chk_wr("single.after", 1'b0, 5'd5, 32'hDEADBEEF);

    // Round-robin from a fresh pointer: grants 0,1,2,0,1,2 with writes every cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_wr("rst2", 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'h100 + DW'(i));
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      chk_eq($sformatf("rr%0d.ready", k), 64'(bus.req_ready), 64'(exp_g));
      tick();
      chk_wr($sformatf("rr%0d.wr", k), 1'b1, AW'((k % 3) + 1), 32'h100 + DW'(k % 3));
    end
    bus.req_valid = '0;

    // Address 0: accepted, no RF write, pointer moves to 1 so 2 beats 0 next
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    chk_eq("z.ready", 64'(bus.req_ready), 64'b010);
    tick();
    bus.req_valid = '0;
    chk_wr("z.wr", 1'b0, 5'd0, 32'h1234);
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(2, 1'b1, 5'd3, 32'h102);
    #1;
    chk_eq("z.next_ready", 64'(bus.req_ready), 64'b100);
    tick();
    bus.req_valid = '0;
    chk_wr("z.next_wr", 1'b1, 5'd3, 32'h102);

    // Hold: accept of requester 0, then 3 held cycles, then requester 1 resumes
    set_req(0, 1'b1, 5'd9,  32'h900);
    set_req(1, 1'b1, 5'd10, 32'hA00);
    #1;
    chk_eq("hold.pre_ready", 64'(bus.req_ready), 64'b001);
    tick();
    bus.hold = 1'b1;
    #1;
    chk_wr("hold.inflight", 1'b1, 5'd9, 32'h900);
    chk_eq("hold.ready1", 64'(bus.req_ready), 64'b000);
    tick();
    chk_eq("hold.we2", 64'(bus.RegWrite), 64'b0);
    chk_eq("hold.ready2", 64'(bus.req_ready), 64'b000);
    tick();
    chk_eq("hold.we3", 64'(bus.RegWrite), 64'b0);
    chk_eq("hold.ready3", 64'(bus.req_ready), 64'b000);
    tick();
    bus.hold = 1'b0;
    #1;
    chk_eq("hold.we4", 64'(bus.RegWrite), 64'b0);
    chk_eq("hold.resume_ready", 64'(bus.req_ready), 64'b010);
    tick();
    bus.req_valid = '0;
    chk_wr("hold.resume_wr", 1'b1, 5'd10, 32'hA00);

    // Bypass on an in-flight write, then reset discards it
    set_req(2, 1'b1, 5'd7, 32'hA5A5A5A5);
    bus.q_addr1 = 5'd7;
    bus.q_addr2 = 5'd0;
    #1;
    chk_eq("byp.ready", 64'(bus.req_ready), 64'b100);
    tick();
    bus.req_valid = '0;
    #1;
    chk_eq("byp.hit1",  64'(bus.q_hit1),  64'b1);
    chk_eq("byp.data1", 64'(bus.q_data1), 64'hA5A5A5A5);
    chk_eq("byp.hit2",  64'(bus.q_hit2),  64'b0);
    chk_eq("byp.data2", 64'(bus.q_data2), 64'h0);
    bus.q_addr2 = 5'd3;
    #1;
    chk_eq("byp.miss_hit2", 64'(bus.q_hit2), 64'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_wr("byp.rst", 1'b0, 5'd0, 32'd0);
    chk_eq("byp.rst_hit1",  64'(bus.q_hit1),  64'b0);
    chk_eq("byp.rst_data1", 64'(bus.q_data1), 64'h0);
    bus.req_valid = 3'b110;
    #1;
    chk_eq("byp.rst_ptr", 64'(bus.req_ready), 64'b010);
    bus.req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between NREQ write-back requesters, e.g. ALU result, load data and mul/div result.
- Each requester uses a valid/ready handshake. Round-robin arbitration picks one write per cycle.
- The winner is registered, so the RF write fires one cycle after acceptance, driving RegWrite/WriteAddr/WriteData.
- A combinational bypass query exposes the in-flight write so read-port consumers see the value the RF has not yet committed.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- hold  in  1  blocks new grants; an in-flight write still commits.
- RegWrite  out  1  RF write enable.
- WriteAddr  out  AW  RF write address.
- WriteData  out  DW  RF write data.
- q_addr1, q_addr2  in  AW each  bypass query addresses (RF ReadAddr1/2).
- q_hit1, q_hit2  out  1 each  query matches the in-flight write.
- q_data1, q_data2  out  DW each  bypass data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - RegWrite=0, WriteAddr=0, WriteData=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
  - Any in-flight write is dropped.
  - req_ready is forced to 0 combinationally while rst=1.
- Arbitration (combinational):
  - Search req_valid starting at index (last+1) mod NREQ, wrapping; the first valid index wins.
  - req_ready[i] = win[i] & ~hold & ~rst.
  - req_ready may depend on req_valid. A requester must hold valid/addr/data stable until it sees ready.
- Accept:
  - Accept occurs when req_valid[i] & req_ready[i] are both high at a clock edge.
  - On that edge: last <= i; WriteAddr <= req_addr[i]; WriteData <= req_data[i]; RegWrite <= (req_addr[i] != 0).
- Write to address 0 is accepted (ready pulses) but RegWrite stays 0. The pointer still advances.
- No accept at an edge (no valid, or hold=1): RegWrite <= 0. WriteAddr/WriteData hold their previous values.
- Latency and throughput:
  - Accept at edge N, RF write at edge N+1.
  - Throughput is one write per cycle, with back-to-back grants allowed.
- Pointer moves only on accept. hold or an idle cycle leaves it unchanged.
- Fairness: with all NREQ requesters continuously valid, grant order is 0,1,...,NREQ-1,0,...; any requester waits at most NREQ-1 grants.
- Same destination address from two requesters in the same cycle: only the winner is accepted; the other is served in a later cycle. Ordering between requesters is the producers' responsibility.
- hold:
  - While hold=1, no req_ready and no new accepts.
  - A write registered before hold rose still pulses RegWrite for its one cycle.
- Bypass (combinational):
  - q_hitK = RegWrite & (WriteAddr == q_addrK) & (q_addrK != 0).
  - q_dataK = WriteData when q_hitK, else 0.
- Reset asserted mid-stream: any registered write is discarded at that edge (RegWrite=0 next cycle), and the pointer returns to NREQ-1.

Decomposition:
- Shared package rf_pkg: AW, DW, NREQ defaults, and the REG_ZERO=0 address constant.
- One sub-module: rr_arbiter (NREQ-wide).
  - Inputs: clk, rst, req, advance.
  - Outputs: one-hot grant and the pointer register.
- Register stage, addr-0 filter and bypass compare stay in rf_wb_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> RegWrite=0, WriteAddr=0, WriteData=0, req_ready=000; first request after reset from all three grants requester 0.
- Single write: req_valid=001, addr=5, data=0xDEADBEEF at edge N -> req_ready[0]=1 in cycle N; at N+1 RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF for exactly one cycle.
- Round-robin: req_valid=111 held with distinct addrs 1,2,3 re-presented after each accept -> grant sequence 0,1,2,0,1,2; RegWrite high every cycle.
- Addr-0 drop: requester 1 writes addr=0, data=0x1234 -> req_ready[1]=1, RegWrite stays 0, pointer advances; next contest between 0 and 2 grants 2.
- hold: accept at edge N, hold=1 from cycle N+1 for 3 cycles with valid=011 -> RegWrite=1 at N+1 only, then 0; no req_ready during hold; grant resumes at the pointer position afterwards.
- Bypass and reset: in-flight write addr=7, data=0xA5A5A5A5 with q_addr1=7, q_addr2=0 -> q_hit1=1, q_data1=0xA5A5A5A5, q_hit2=0; then rst=1 at that edge -> RegWrite=0 next cycle, q_hit1=0.
